// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: clock-enable bit timing, valid/ready TX,
// mid-bit sampling RX behind a 2-flop synchroniser, parity and framing flags.
module uart_param_core #(
    parameter int DATA_BITS    = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out_bit,
    input  logic                 rx_in_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY_MODE != 0);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_MODE == 2);
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t              tx_state, tx_state_nx;
    logic [CNT_W-1:0]       tx_cnt;
    logic [3:0]             tx_idx;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_bit_end;
    logic                   tx_take;

    assign tx_bit_end = (tx_cnt == CNT_LAST);
    assign tx_take    = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_take) tx_state_nx = TX_START;
            TX_START:  if (tx_bit_end) tx_state_nx = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_idx == DATA_LAST)
                           tx_state_nx = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_idx == STOP_LAST) tx_state_nx = TX_IDLE;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = (tx_state == TX_IDLE);
        tx_out_bit = 1'b1;
        case (tx_state)
            TX_START:  tx_out_bit = 1'b0;
            TX_DATA:   tx_out_bit = tx_shift[0];
            TX_PARITY: tx_out_bit = tx_par;
            default:   tx_out_bit = 1'b1;
        endcase
    end

    // Idle holds the counter at zero so START always gets a full bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
            tx_idx <= '0;
        end else begin
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            if (tx_state != tx_state_nx)
                tx_idx <= '0;
            else if (tx_bit_end && (tx_state == TX_DATA || tx_state == TX_STOP))
                tx_idx <= tx_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_take) begin
            tx_shift <= tx_data;
            tx_par   <= parity_of(tx_data);
        end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // Synchroniser stages p0 -> p1
    logic sync_p0, sync_p1;
    logic rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx_in_bit;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_sync = sync_p1;

    rx_state_t              rx_state, rx_state_nx;
    logic [CNT_W-1:0]       rx_cnt;
    logic [3:0]             rx_idx;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par;
    logic                   rx_half;
    logic                   rx_tick;
    logic                   rx_stop_tick;

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_sync) rx_state_nx = RX_START;
            RX_START:     if (rx_half) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_idx == DATA_LAST)
                              rx_state_nx = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_tick) rx_state_nx = RX_STOP;
            RX_STOP:      if (rx_tick) rx_state_nx = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_state_nx = RX_IDLE;
            default:      rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_half      = (rx_state == RX_START) && (rx_cnt == CNT_HALF);
        rx_tick      = (rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP)
                       && (rx_cnt == CNT_LAST);
        rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == CNT_LAST);
    end

    // After the half-bit start check, every tick lands on a bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= '0;
            rx_idx <= '0;
        end else begin
            if (rx_state != rx_state_nx || rx_state == RX_IDLE ||
                rx_state == RX_WAIT_HIGH || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state != rx_state_nx)
                rx_idx <= '0;
            else if (rx_tick && rx_state == RX_DATA)
                rx_idx <= rx_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_tick && rx_state == RX_DATA)   rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
        if (rx_tick && rx_state == RX_PARITY) rx_par   <= rx_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= rx_stop_tick;
            if (rx_stop_tick) begin
                rx_data       <= rx_shift;
                rx_parity_err <= HAS_PARITY && (rx_par != parity_of(rx_shift));
                rx_frame_err  <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: two configurations (7E1 and 7N2, 4 clocks/bit),
// randomized loopback and directly driven RX frames against a frame-level model.
module tb_uart_param_core;

    localparam int CPB = 4;

    typedef struct packed {
        logic [6:0] d;
        logic       pe;
        logic       fe;
    } rx_rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tx_valid;
    logic [6:0] tx_data [2];
    logic       loop0;
    logic       rx_drive;
    wire  [1:0] tx_ready, tx_out, rx_valid, perr, ferr;
    wire  [6:0] rx_data0, rx_data1;
    wire        rx_in0 = loop0 ? tx_out[0] : rx_drive;
    wire        rx_in1 = tx_out[1];

    int      checks = 0;
    int      errors = 0;
    bit      frame_q[$];
    rx_rec_t got0[$];
    rx_rec_t got1[$];

    always #5 clk = ~clk;

    uart_param_core #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_out_bit(tx_out[0]), .rx_in_bit(rx_in0),
        .rx_data(rx_data0), .rx_valid(rx_valid[0]), .rx_parity_err(perr[0]),
        .rx_frame_err(ferr[0]));

    uart_param_core #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_out_bit(tx_out[1]), .rx_in_bit(rx_in1),
        .rx_data(rx_data1), .rx_valid(rx_valid[1]), .rx_parity_err(perr[1]),
        .rx_frame_err(ferr[1]));

    always @(negedge clk) begin
        if (rx_valid[0]) got0.push_back('{d: rx_data0, pe: perr[0], fe: ferr[0]});
        if (rx_valid[1]) got1.push_back('{d: rx_data1, pe: perr[1], fe: ferr[1]});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pm_of(input int sel);
        return (sel == 0) ? 1 : 0;
    endfunction

    function automatic int sb_of(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    // Frame model: start, data LSB first, optional parity, stop bit(s).
    function automatic void build_frame(input logic [6:0] d, input int pm, input int sb,
                                        input bit bad_par, input bit stop_low);
        int ones = 0;
        bit p;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) begin
            frame_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm != 0) begin
            p = (ones % 2) == 1;
            if (pm == 2) p = !p;
            frame_q.push_back(p ^ bad_par);
        end
        frame_q.push_back(!stop_low);
        for (int i = 1; i < sb; i++) frame_q.push_back(1'b1);
    endfunction

    task automatic handshake(input int sel, input logic [6:0] d, input bit hold);
        int n = 0;
        @(negedge clk);
        tx_data[sel]  = d;
        tx_valid[sel] = 1'b1;
        while (!tx_ready[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("hs_ready_seen", (n < 200), 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid[sel] = 1'b0;
    endtask

    task automatic tx_frame_check(input int sel, input logic [6:0] d, input bit scramble);
        int busy = 0;
        int pm   = pm_of(sel);
        int sb   = sb_of(sel);
        build_frame(d, pm, sb, 1'b0, 1'b0);
        for (int i = 0; i < frame_q.size() * CPB; i++) begin
            @(negedge clk);
            check_val($sformatf("tx_line%0d_c%0d", sel, i), tx_out[sel], frame_q[i / CPB]);
            if (!tx_ready[sel]) busy++;
            if (scramble) tx_data[sel] = 7'($urandom);
        end
        check_val("tx_busy_len", busy, (1 + 7 + ((pm != 0) ? 1 : 0) + sb) * CPB);
    endtask

    task automatic tx_ready_after(input int sel);
        @(negedge clk);
        check_val("tx_ready_end", tx_ready[sel], 1);
        check_val("tx_idle_line", tx_out[sel], 1);
    endtask

    task automatic expect_rx(input int sel, input logic [6:0] d, input logic pe, input logic fe);
        int      n = 0;
        int      sz;
        rx_rec_t r;
        sz = (sel == 0) ? got0.size() : got1.size();
        while (sz == 0 && n < 200) begin
            @(negedge clk);
            n++;
            sz = (sel == 0) ? got0.size() : got1.size();
        end
        check_val("rx_valid_seen", (sz > 0), 1);
        if (sz > 0) begin
            if (sel == 0) r = got0.pop_front();
            else          r = got1.pop_front();
            check_val("rx_data", r.d, d);
            check_val("rx_parity_err", r.pe, pe);
            check_val("rx_frame_err", r.fe, fe);
        end
    endtask

    task automatic expect_no_rx(input int sel, input int cycles);
        repeat (cycles) @(negedge clk);
        check_val("rx_extra_valid", (sel == 0) ? got0.size() : got1.size(), 0);
    endtask

    task automatic rx_drive_frame(input logic [6:0] d, input bit bad_par, input bit stop_low,
                                  input int hold_bits);
        build_frame(d, 1, 1, bad_par, stop_low);
        foreach (frame_q[i]) begin
            rx_drive = frame_q[i];
            repeat (CPB) @(negedge clk);
        end
        if (hold_bits > 0) begin
            rx_drive = 1'b0;
            repeat (hold_bits * CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic reset_mid_frame(input int sel, input logic [6:0] d, input logic [6:0] d2);
        handshake(sel, d, 1'b0);
        repeat (14) @(negedge clk);
        check_val("tx_data_bit2", tx_out[sel], d[2]);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_tx_line", tx_out[sel], 1);
        check_val("rst_tx_ready", tx_ready[sel], 1);
        check_val("rst_rx_valid", rx_valid[sel], 0);
        check_val("rst_rx_data", (sel == 0) ? rx_data0 : rx_data1, 0);
        expect_no_rx(sel, 60);
        handshake(sel, d2, 1'b0);
        tx_frame_check(sel, d2, 1'b1);
        tx_ready_after(sel);
        expect_rx(sel, d2, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d;
        bit         bad;
        bit         sl;
        rst = 1'b1;
        tx_valid = 2'b00;
        tx_data[0] = '0;
        tx_data[1] = '0;
        loop0 = 1'b1;
        rx_drive = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_val("reset_tx_line", tx_out[s], 1);
            check_val("reset_tx_ready", tx_ready[s], 1);
            check_val("reset_rx_valid", rx_valid[s], 0);
            check_val("reset_perr", perr[s], 0);
            check_val("reset_ferr", ferr[s], 0);
        end
        check_val("reset_rx_data0", rx_data0, 0);
        check_val("reset_rx_data1", rx_data1, 0);

        // Loopback single word 0x55.
        handshake(0, 7'h55, 1'b0);
        tx_frame_check(0, 7'h55, 1'b1);
        tx_ready_after(0);
        expect_rx(0, 7'h55, 1'b0, 1'b0);
        expect_no_rx(0, 20);

        // Back-to-back 0x07 then 0x7F with tx_valid held.
        handshake(0, 7'h07, 1'b1);
        tx_data[0] = 7'h7F;
        tx_frame_check(0, 7'h07, 1'b0);
        @(negedge clk);
        check_val("b2b_ready", tx_ready[0], 1);
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        tx_frame_check(0, 7'h7F, 1'b1);
        tx_ready_after(0);
        expect_rx(0, 7'h07, 1'b0, 1'b0);
        expect_rx(0, 7'h7F, 1'b0, 1'b0);
        expect_no_rx(0, 10);

        // Random loopback words.
        repeat (6) begin
            d = 7'($urandom);
            handshake(0, d, 1'b0);
            tx_frame_check(0, d, 1'b1);
            tx_ready_after(0);
            expect_rx(0, d, 1'b0, 1'b0);
        end

        // Directly driven RX frames.
        loop0 = 1'b0;
        rx_drive = 1'b1;
        repeat (8) @(negedge clk);
        rx_drive_frame(7'h23, 1'b1, 1'b0, 0);
        expect_rx(0, 7'h23, 1'b1, 1'b0);
        expect_no_rx(0, 4);

        rx_drive_frame(7'h4A, 1'b0, 1'b1, 5);
        expect_rx(0, 7'h4A, 1'b0, 1'b1);
        expect_no_rx(0, 4);
        rx_drive_frame(7'h31, 1'b0, 1'b0, 0);
        expect_rx(0, 7'h31, 1'b0, 1'b0);

        rx_drive = 1'b0;
        @(negedge clk);
        rx_drive = 1'b1;
        expect_no_rx(0, 3 * CPB);
        rx_drive_frame(7'h5A, 1'b0, 1'b0, 0);
        expect_rx(0, 7'h5A, 1'b0, 1'b0);

        repeat (8) begin
            d   = 7'($urandom);
            bad = 1'($urandom);
            sl  = ($urandom_range(0, 3) == 0);
            rx_drive_frame(d, bad, sl, sl ? 2 : 0);
            expect_rx(0, d, bad, sl);
        end
        expect_no_rx(0, 4);

        // Reset during the third data bit.
        loop0 = 1'b1;
        repeat (4) @(negedge clk);
        reset_mid_frame(0, 7'($urandom), 7'h2C);

        // No parity, two stop bits.
        repeat (3) begin
            d = 7'($urandom);
            handshake(1, d, 1'b0);
            tx_frame_check(1, d, 1'b1);
            tx_ready_after(1);
            expect_rx(1, d, 1'b0, 1'b0);
        end
        reset_mid_frame(1, 7'($urandom), 7'($urandom));
        expect_no_rx(1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
